// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the memory arbiter slice.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } arb_state_t;

  localparam logic [2:0]  LEN_B    = 3'd1;
  localparam logic [2:0]  LEN_H    = 3'd2;
  localparam logic [2:0]  LEN_W    = 3'd4;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/mem_store_buf.sv
// One-entry posted store buffer with word-address hazard compare.
// Only instantiated when STORE_BUF_EN is defined.
module mem_store_buf
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-3:0] i_ld_word,
  output logic              o_accept,
  output logic              o_valid,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_len,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_len;
  logic [DATA_W-1:0] r_data;

  assign o_accept = i_push && !r_valid;
  assign o_valid  = r_valid;
  assign o_hit    = r_valid && (r_addr[ADDR_W-1:2] == i_ld_word);
  assign o_addr   = r_addr;
  assign o_len    = r_len;
  assign o_data   = r_data;

  // Entry capture on accept, release when the drain write completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_len   <= 3'd0;
      r_data  <= '0;
    end else if (i_en) begin
      if (o_accept) begin
        r_valid <= 1'b1;
        r_addr  <= i_addr;
        r_len   <= i_len;
        r_data  <= i_data;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch, load and store traffic onto one byte-serial memory controller.
// Define STORE_BUF_EN to post stores through a one-entry buffer (mem_store_buf).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_data,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ack,
  output logic              mc_valid,
  output logic              mc_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t        r_state;
  logic [SW-1:0]     r_starve;
  logic              r_discard;
  arb_state_t        w_grant;
  logic              w_if_cand;
  logic              w_ld_cand;
  logic              w_st_pend;
  logic [ADDR_W-1:0] w_st_addr;
  logic [2:0]        w_st_len;
  logic [DATA_W-1:0] w_st_wdata;
  logic              w_ld_block;
  logic              w_st_ack_set;

  function automatic logic [DATA_W-1:0] mask_load(input logic [DATA_W-1:0] d,
                                                   input logic [2:0] len);
    logic [DATA_W-1:0] m;
    case (len)
      LEN_B:   m = DATA_W'(32'h0000_00FF);
      LEN_H:   m = DATA_W'(32'h0000_FFFF);
      default: m = '1;
    endcase
    return d & m;
  endfunction

`ifdef STORE_BUF_EN
  mem_store_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_store_buf (
    .clk       (clk),
    .rst       (rst),
    .i_en      (rdy),
    .i_push    (st_req && !st_ack),
    .i_pop     ((r_state == ST_STORE) && mc_done),
    .i_addr    (st_addr),
    .i_len     (st_len),
    .i_data    (st_data),
    .i_ld_word (ld_addr[ADDR_W-1:2]),
    .o_accept  (w_st_ack_set),
    .o_valid   (w_st_pend),
    .o_hit     (w_ld_block),
    .o_addr    (w_st_addr),
    .o_len     (w_st_len),
    .o_data    (w_st_wdata)
  );
`else
  assign w_st_pend    = st_req && !st_ack;
  assign w_st_addr    = st_addr;
  assign w_st_len     = st_len;
  assign w_st_wdata   = st_data;
  assign w_ld_block   = 1'b0;
  assign w_st_ack_set = (r_state == ST_STORE) && mc_done;
`endif

  // A requester whose ack is high this cycle is still holding a satisfied request.
  assign w_if_cand = if_req && !if_ack && !flush;
  assign w_ld_cand = ld_req && !ld_ack && !flush && !w_ld_block;

  // Grant selection, only meaningful while idle.
  always_comb begin
    w_grant = ST_IDLE;
    if (r_state == ST_IDLE) begin
      if (w_if_cand && (r_starve == STARVE_LIM)) w_grant = ST_FETCH;
      else if (w_st_pend)                        w_grant = ST_STORE;
      else if (w_ld_cand)                        w_grant = ST_LOAD;
      else if (w_if_cand)                        w_grant = ST_FETCH;
      else                                       w_grant = ST_IDLE;
    end else begin
      w_grant = ST_IDLE;
    end
  end

  // Transaction sequencing, starvation tracking and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_starve  <= '0;
      r_discard <= 1'b0;
      if_ack    <= 1'b0;
      if_data   <= '0;
      ld_ack    <= 1'b0;
      ld_data   <= '0;
      st_ack    <= 1'b0;
      mc_valid  <= 1'b0;
      mc_write  <= 1'b0;
      mc_addr   <= '0;
      mc_len    <= 3'd0;
      mc_wdata  <= '0;
    end else if (rdy) begin
      if_ack <= 1'b0;
      ld_ack <= 1'b0;
      st_ack <= w_st_ack_set;
      if (!if_req || (w_grant == ST_FETCH)) begin
        r_starve <= '0;
      end else if (((w_grant == ST_STORE) || (w_grant == ST_LOAD)) && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + SW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= w_grant;
          case (w_grant)
            ST_FETCH: begin
              mc_valid <= 1'b1;
              mc_write <= 1'b0;
              mc_addr  <= if_addr;
              mc_len   <= LEN_W;
              mc_wdata <= DATA_W'(ZeroWord);
            end
            ST_LOAD: begin
              mc_valid <= 1'b1;
              mc_write <= 1'b0;
              mc_addr  <= ld_addr;
              mc_len   <= ld_len;
              mc_wdata <= DATA_W'(ZeroWord);
            end
            ST_STORE: begin
              mc_valid <= 1'b1;
              mc_write <= 1'b1;
              mc_addr  <= w_st_addr;
              mc_len   <= w_st_len;
              mc_wdata <= w_st_wdata;
            end
            default: ;
          endcase
        end
        ST_FETCH, ST_LOAD: begin
          if (mc_done) begin
            r_state   <= ST_IDLE;
            mc_valid  <= 1'b0;
            r_discard <= 1'b0;
            // A flush arriving with mc_done discards the result just like an earlier one.
            if (!(r_discard || flush)) begin
              if (r_state == ST_FETCH) begin
                if_ack  <= 1'b1;
                if_data <= mc_rdata;
              end else begin
                ld_ack  <= 1'b1;
                ld_data <= mask_load(mc_rdata, mc_len);
              end
            end
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        ST_STORE: begin
          if (mc_done) begin
            r_state  <= ST_IDLE;
            mc_valid <= 1'b0;
            mc_write <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default build) with a cycle-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic clk, rst, rdy, flush;
  logic if_req, if_ack, ld_req, ld_ack, st_req, st_ack;
  logic [AW-1:0] if_addr, ld_addr, st_addr, mc_addr;
  logic [DW-1:0] if_data, ld_data, st_data, mc_wdata, mc_rdata;
  logic [2:0] ld_len, st_len, mc_len;
  logic mc_valid, mc_write, mc_done;

  int n_tests = 0;
  int n_fail = 0;
  int lat = 3;
  logic [DW-1:0] rd_val = 32'h0;
  logic [AW-1:0] grant_log[$];
  int ld_ack_cnt = 0;

  // model state
  logic m_busy, m_fetch, m_write, m_disc, m_af, m_al, m_as, prev_valid;
  logic [AW-1:0] m_addr;
  logic [2:0] m_len;
  logic [DW-1:0] m_wdata, m_if_data, m_ld_data;
  int m_starve;
  // inputs as sampled at the next active edge
  logic p_rdy, p_flush, p_if_req, p_ld_req, p_st_req, p_done;
  logic [AW-1:0] p_if_addr, p_ld_addr, p_st_addr;
  logic [2:0] p_ld_len, p_st_len;
  logic [DW-1:0] p_st_data, p_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_ack(ld_ack), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_ack(st_ack),
    .mc_valid(mc_valid), .mc_write(mc_write), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_mask(input logic [31:0] d, input logic [2:0] len);
    if (len == 3'd4) return d;
    return d & ((32'd1 << (8 * len)) - 32'd1);
  endfunction

  // Memory controller: completes each request lat cycles after it appears.
  initial begin : mc_model
    int cnt;
    cnt = 0;
    mc_done = 1'b0;
    mc_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        cnt = 0;
        mc_done = 1'b0;
      end else if (mc_done) begin
        mc_done = 1'b0;
      end else if (mc_valid) begin
        cnt++;
        if (cnt >= lat) begin
          mc_done = 1'b1;
          mc_rdata = rd_val;
          cnt = 0;
        end
      end
    end
  end

  // Reference model advance plus per-cycle output comparison.
  always @(negedge clk) begin : compare
    logic nf, nl, ns, cf, cl, cs, gf, gs, gl;
    if (!rst) begin
      m_busy = 1'b0; m_disc = 1'b0; m_starve = 0;
      m_af = 1'b0; m_al = 1'b0; m_as = 1'b0; prev_valid = 1'b0;
      m_if_data = '0; m_ld_data = '0;
    end else begin
      if (p_rdy) begin
        nf = 1'b0; nl = 1'b0; ns = 1'b0;
        if (m_busy) begin
          if (p_done) begin
            if (m_write) ns = 1'b1;
            else if (!(m_disc || p_flush)) begin
              if (m_fetch) begin nf = 1'b1; m_if_data = p_rdata; end
              else begin nl = 1'b1; m_ld_data = exp_mask(p_rdata, m_len); end
            end
            m_busy = 1'b0;
            m_disc = 1'b0;
          end else if (p_flush && !m_write) begin
            m_disc = 1'b1;
          end
          if (!p_if_req) m_starve = 0;
        end else begin
          cf = p_if_req && !m_af && !p_flush;
          cl = p_ld_req && !m_al && !p_flush;
          cs = p_st_req && !m_as;
          gf = cf && ((m_starve == SMAX) || (!cs && !cl));
          gs = !gf && cs;
          gl = !gf && !cs && cl;
          if (!p_if_req || gf) m_starve = 0;
          else if ((gs || gl) && m_starve < SMAX) m_starve++;
          if (gf) begin
            m_busy = 1'b1; m_fetch = 1'b1; m_write = 1'b0; m_addr = p_if_addr; m_len = 3'd4;
          end else if (gs) begin
            m_busy = 1'b1; m_fetch = 1'b0; m_write = 1'b1; m_addr = p_st_addr;
            m_len = p_st_len; m_wdata = p_st_data;
          end else if (gl) begin
            m_busy = 1'b1; m_fetch = 1'b0; m_write = 1'b0; m_addr = p_ld_addr; m_len = p_ld_len;
          end
        end
        m_af = nf; m_al = nl; m_as = ns;
      end
      check("mc_valid", mc_valid, m_busy);
      if (m_busy) begin
        check("mc_write", mc_write, m_write);
        check("mc_addr", mc_addr, m_addr);
        check("mc_len", mc_len, m_len);
        if (m_write) check("mc_wdata", mc_wdata, m_wdata);
      end
      check("if_ack", if_ack, m_af);
      check("ld_ack", ld_ack, m_al);
      check("st_ack", st_ack, m_as);
      if (m_af) check("if_data", if_data, m_if_data);
      if (m_al) check("ld_data", ld_data, m_ld_data);
      if (mc_valid && !prev_valid) grant_log.push_back(mc_addr);
      if (ld_ack) ld_ack_cnt++;
      prev_valid = mc_valid;
    end
    p_rdy = rdy; p_flush = flush; p_done = mc_done; p_rdata = mc_rdata;
    p_if_req = if_req; p_if_addr = if_addr;
    p_ld_req = ld_req; p_ld_addr = ld_addr; p_ld_len = ld_len;
    p_st_req = st_req; p_st_addr = st_addr; p_st_len = st_len; p_st_data = st_data;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return mc_valid;
      1: return if_ack;
      2: return ld_ack;
      3: return st_ack;
      default: return mc_done;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int w, input int max);
    int i;
    i = 0;
    while (!sig(w) && i < max) begin
      step(1);
      i++;
    end
    n_tests++;
    if (!sig(w)) begin
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles", nm, max);
    end
  endtask

  task automatic check_log(input string nm, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                           input logic [AW-1:0] e2, input int n);
    logic [AW-1:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({nm, " count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < 3 && i < grant_log.size(); i++) check({nm, " order"}, grant_log[i], e[i]);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0, k;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_addr = '0; ld_len = 3'd4;
    st_req = 1'b0; st_addr = '0; st_len = 3'd4; st_data = '0;
    step(2);
    check("reset mc_valid", mc_valid, 1'b0);
    check("reset mc_addr", mc_addr, 32'h0);
    check("reset acks", {if_ack, ld_ack, st_ack}, 3'b000);
    check("reset if_data", if_data, 32'h0);
    rst = 1'b1;
    step(1);

    // fetch only
    lat = 5; rd_val = 32'hDEADBEEF; if_addr = 32'h100; if_req = 1'b1;
    wait_for("fetch grant", 0, 5);
    check("fetch mc_len", mc_len, 3'd4);
    wait_for("fetch ack", 1, 20);
    check("fetch if_data", if_data, 32'hDEADBEEF);
    step(1);
    check("no regrant in ack cycle", mc_valid, 1'b0);
    if_req = 1'b0;
    step(1);

    // priority store > load > fetch
    grant_log.delete(); lat = 2;
    if_addr = 32'h300; ld_addr = 32'h400; ld_len = 3'd4;
    st_addr = 32'h500; st_len = 3'd4; st_data = 32'hCAFEF00D;
    if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
    k = 0;
    while ((if_req || ld_req || st_req) && k < 40) begin
      step(1);
      if (st_ack) st_req = 1'b0;
      if (ld_ack) ld_req = 1'b0;
      if (if_ack) if_req = 1'b0;
      k++;
    end
    step(2);
    check_log("priority", 32'h500, 32'h400, 32'h300, 3);

    // starvation: four data grants, then fetch wins
    grant_log.delete(); lat = 1;
    if_addr = 32'h600; ld_addr = 32'h700; st_addr = 32'h800; st_len = 3'd2; st_data = 32'h0BADF00D;
    if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
    wait_for("starve fetch ack", 1, 60);
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    step(3);
    check("starve grants", grant_log.size(), 5);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("starve data first", grant_log[i], (i % 2 == 0) ? 32'h800 : 32'h700);
    if (grant_log.size() >= 5) check("starve 5th is fetch", grant_log[4], 32'h600);

    // flush in flight discards, refetch proceeds
    grant_log.delete(); lat = 4; rd_val = 32'hA5A5A5A5; if_addr = 32'h100; if_req = 1'b1;
    wait_for("flush grant", 0, 5);
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0; if_addr = 32'h200;
    wait_for("refetch ack", 1, 30);
    check("refetch if_data", if_data, 32'hA5A5A5A5);
    if_req = 1'b0;
    step(2);
    check_log("flush", 32'h100, 32'h200, 32'h0, 2);

    // flush in IDLE blocks a fetch grant for that cycle
    if_addr = 32'h240; if_req = 1'b1; flush = 1'b1;
    step(1);
    check("idle flush blocks fetch", mc_valid, 1'b0);
    flush = 1'b0;
    wait_for("post-flush grant", 0, 3);
    check("post-flush addr", mc_addr, 32'h240);
    wait_for("post-flush ack", 1, 20);
    if_req = 1'b0;
    step(1);

    // load masking
    rd_val = 32'h12345678; lat = 2; ld_addr = 32'h40;
    ld_len = 3'd1; ld_req = 1'b1;
    wait_for("ld1 ack", 2, 20);
    check("ld len1 data", ld_data, 32'h00000078);
    ld_req = 1'b0; step(1);
    ld_len = 3'd2; ld_req = 1'b1;
    wait_for("ld2 ack", 2, 20);
    check("ld len2 data", ld_data, 32'h00005678);
    ld_req = 1'b0; step(1);
    ld_len = 3'd4; ld_req = 1'b1;
    wait_for("ld4 ack", 2, 20);
    check("ld len4 data", ld_data, 32'h12345678);
    ld_req = 1'b0; step(1);

    // flush coinciding with mc_done suppresses the ack
    c0 = ld_ack_cnt; lat = 3; ld_addr = 32'h900; ld_req = 1'b1;
    wait_for("flush-done grant", 0, 5);
    wait_for("flush-done done", 4, 10);
    flush = 1'b1; ld_req = 1'b0;
    step(1);
    flush = 1'b0;
    step(3);
    check("flush at done no ld_ack", ld_ack_cnt - c0, 0);

    // rdy low freezes an in-flight load
    lat = 6; rd_val = 32'hCAFEBEEF; ld_addr = 32'hA0; ld_len = 3'd2; ld_req = 1'b1;
    wait_for("rdy grant", 0, 5);
    rdy = 1'b0;
    step(2);
    check("rdy freeze mc_valid", mc_valid, 1'b1);
    rdy = 1'b1;
    wait_for("rdy ack", 2, 20);
    check("rdy ld_data", ld_data, 32'h0000BEEF);
    ld_req = 1'b0; step(1);

    // async reset mid-load
    lat = 8; ld_addr = 32'hB0; ld_len = 3'd4; ld_req = 1'b1;
    wait_for("reset-load grant", 0, 5);
    step(2);
    rst = 1'b0;
    #1;
    check("async rst mc_valid", mc_valid, 1'b0);
    check("async rst mc_addr", mc_addr, 32'h0);
    check("async rst mc_len", mc_len, 3'd0);
    check("async rst ld_data", ld_data, 32'h0);
    check("async rst acks", {if_ack, ld_ack, st_ack}, 3'b000);
    ld_req = 1'b0;
    step(1);
    rst = 1'b1;
    step(2);
    check("post-reset idle", mc_valid, 1'b0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-serial memory controller between three requesters: instruction fetch, LSU loads, and committed stores.
- Sits between the fetch/LSU front ends and the memory controller.
- Decides every transaction, holds the controller request stable until completion, and routes results back.
- Handles flush discards, fetch starvation and, optionally, a one-entry posted store buffer.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low
- rdy  in  1  global enable; low freezes all state and outputs
- flush  in  1  jump/mispredict clear
- if_req  in  1  fetch request (level, held until if_ack)
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_data valid
- if_data  out  DATA_W  fetched word
- ld_req  in  1  load request (level)
- ld_addr  in  ADDR_W  load address
- ld_len  in  3  byte count: 1, 2 or 4
- ld_ack  out  1  one-cycle pulse; ld_data valid
- ld_data  out  DATA_W  load data, bytes above ld_len zeroed
- st_req  in  1  store request (level)
- st_addr  in  ADDR_W  store address
- st_len  in  3  byte count: 1, 2 or 4
- st_data  in  DATA_W  store data
- st_ack  out  1  one-cycle pulse; store accepted
- mc_valid  out  1  transaction request to memory controller
- mc_write  out  1  1 = write
- mc_addr  out  ADDR_W  start address
- mc_len  out  3  byte count
- mc_wdata  out  DATA_W  write data
- mc_done  in  1  one-cycle completion pulse
- mc_rdata  in  DATA_W  read data, valid with mc_done

## Operation
- States: IDLE, FETCH, LOAD, STORE.
- Arbitration is evaluated only in IDLE.
- Default priority is store > load > fetch.
  - Exception: when the starvation counter equals STARVE_MAX, fetch wins.
- Starvation counter:
  - Increments on each load/store grant while if_req is high.
  - Clears on a fetch grant or when if_req is low.
  - Saturates at STARVE_MAX.
- On a grant:
  - Latch mc_addr, mc_len and mc_wdata, and set mc_write (STORE only).
  - Fetch always uses mc_len = 4.
- The arbiter ignores a requester whose ack is high in the current cycle, so a held request is not re-granted.
- On mc_done in FETCH or LOAD:
  - If the discard flag is clear, pulse the matching ack and drive data.
  - Always clear discard and return to IDLE.
- On mc_done in STORE: pulse st_ack (unbuffered build only) and return to IDLE.
- flush behaviour:
  - In IDLE: suppresses fetch and load grants for that cycle.
  - In FETCH or LOAD: sets discard. The transaction runs to completion, because the controller cannot abort, but produces no ack.
  - Never affects STORE state or a buffered store.
- ld_data masking: len 1 keeps [7:0]; len 2 keeps [15:0]; all upper bits are zero.
- Reset values:
  - All outputs 0.
  - State IDLE, counter 0, discard 0, buffer invalid.
- Reset mid-transaction clears everything immediately. The controller shares the reset, so no stale mc_done arrives.
- rdy low: no transitions; mc_done and flush are ignored.

## Timing
- Request sampled high in IDLE at edge N → mc_valid high from after edge N.
- mc_valid and all mc_* are held stable until mc_done is sampled.
- mc_done sampled at edge M → mc_valid low and ack high for exactly one cycle after edge M.
- The state is IDLE in that same cycle, so the next grant makes mc_valid rise after edge M+1.
- Minimum gap between transactions: one cycle of mc_valid low.
- flush coinciding with mc_done: discard applies and the ack is suppressed.

## Configuration
- STORE_BUF_EN defined:
  - A one-entry posted buffer accepts st_req whenever it is empty, in any state.
  - st_ack pulses the cycle after acceptance.
  - The buffer drains at store priority.
  - A load whose addr[ADDR_W-1:2] matches a valid buffer entry's word address is blocked until the buffer drains.
  - A store arriving while the buffer is full waits.
- STORE_BUF_EN undefined:
  - Stores are granted directly from st_req.
  - st_ack pulses on completion (cycle after mc_done).

## Structure
- Shared config header holds: state encodings, length encodings (LEN_B=1, LEN_H=2, LEN_W=4), ZeroWord, ADDR_W/DATA_W defaults.
- One sub-module, mem_store_buf (entry regs, valid, word-address compare), instantiated only under STORE_BUF_EN.

## Test plan
- Fetch only:
  - Stimulus: if_req, if_addr=0x100; mc_done 5 cycles after mc_valid with mc_rdata=0xDEADBEEF.
  - Response: mc_len=4; if_ack one cycle after mc_done with if_data=0xDEADBEEF; no re-grant during the ack cycle.
- Priority:
  - Stimulus: if_req, ld_req and st_req all raised together.
  - Response: order is STORE, LOAD, FETCH.
  - Stimulus: with STARVE_MAX=4, hold ld_req with 4 back-to-back loads.
  - Response: 5th grant goes to fetch.
- Flush in flight:
  - Stimulus: flush during FETCH.
  - Response: mc_valid held until mc_done; no if_ack; next IDLE grants a new if_addr=0x200.
- Load masking:
  - Stimulus: ld_len=1, mc_rdata=0x12345678.
  - Response: ld_data=0x00000078. Repeat with ld_len=2 → 0x00005678.
- Store buffer (STORE_BUF_EN):
  - Stimulus: st_addr=0x1004 followed by load 0x1006.
  - Response: st_ack next cycle; load blocked until the store's mc_done; load 0x2000 proceeds normally.
- Async reset:
  - Stimulus: assert rst low mid-LOAD.
  - Response: all outputs 0 immediately; after release, state IDLE and buffer empty.
